uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares the single UART TX FIFO write port between up to `N_REQ` byte-stream requesters, such as the CORE store path, an RX echo/loopback path and a debug/status reporter. It sits between the requesters and the TX FIFO `data`/`wrreq` pins, in the `clk0` domain. It holds a grant for a whole packet, throttles on FIFO high-water, and reclaims a grant from a stalled requester after a timeout.

---
 rtl/uart_arb_pkg.sv | 9 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default thresholds for the UART TX write-port arbiter.
package uart_arb_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  localparam int DEF_HIGH_WATER  = 250;
  localparam int DEF_STALL_LIMIT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from ptr+1, modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  // The previous owner (ptr) is visited last, which gives it lowest priority.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IW'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO write port,
// with high-water throttling and timeout reclaim of a stalled grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  USEDW_W     = 8,
  parameter int  HIGH_WATER  = DEF_HIGH_WATER,
  parameter int  STALL_LIMIT = DEF_STALL_LIMIT,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [7:0]            fifo_data,
  output logic                  fifo_wrreq,
  input  logic                  fifo_full,
  input  logic [USEDW_W-1:0]    fifo_usedw,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  stall_abort
);

  localparam int SW = $clog2(STALL_LIMIT);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, grant_nxt;
  logic [SW-1:0] stall_cnt, stall_cnt_nxt;
  logic          busy_nxt, abort_nxt;
  logic          room, beat, cur_valid, cur_last;
  logic          pick_any;
  logic [IW-1:0] pick_idx;

  // usedw lags writes by a cycle; HIGH_WATER leaves headroom so full is never hit.
  assign room      = !fifo_full && (32'(fifo_usedw) < 32'(HIGH_WATER));
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Next-state, grant bookkeeping and the combinational write path.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_nxt     = grant_id;
    busy_nxt      = busy;
    stall_cnt_nxt = stall_cnt;
    abort_nxt     = 1'b0;
    beat          = 1'b0;
    req_ready     = '0;
    fifo_wrreq    = 1'b0;
    fifo_data     = req_data[grant_id];
    case (state)
      IDLE: begin
        if (pick_any && room) begin
          grant_nxt     = pick_idx;
          busy_nxt      = 1'b1;
          stall_cnt_nxt = '0;
          state_nxt     = XFER;
        end else begin
          busy_nxt = 1'b0;
        end
      end
      XFER: begin
        beat                = cur_valid && room;
        req_ready[grant_id] = beat;
        fifo_wrreq          = beat;
        if (beat) begin
          stall_cnt_nxt = '0;
          if (cur_last) begin
            ptr_nxt   = grant_id;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = XFER;
          end
        end else if (!cur_valid && room) begin
          // Only cycles the owner could have used count toward the timeout.
          if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
            abort_nxt     = 1'b1;
            ptr_nxt       = grant_id;
            busy_nxt      = 1'b0;
            stall_cnt_nxt = '0;
            state_nxt     = IDLE;
          end else begin
            stall_cnt_nxt = stall_cnt + SW'(1);
          end
        end else begin
          stall_cnt_nxt = stall_cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IW'(N_REQ - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      stall_cnt   <= '0;
      stall_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_id    <= grant_nxt;
      busy        <= busy_nxt;
      stall_cnt   <= stall_cnt_nxt;
      stall_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic against a packet-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int UW = 8;
  localparam int HW = 250;
  localparam int SL = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid, req_last, req_ready;
  logic [N-1:0][7:0]  req_data;
  logic [7:0]         fifo_data;
  logic               fifo_wrreq, fifo_full;
  logic [UW-1:0]      fifo_usedw;
  logic [1:0]         grant_id;
  logic               busy, stall_abort;

  int errors = 0;
  int checks = 0;

  logic [8:0] q [N][$];
  bit         src_on [N];
  bit         hold [N];

  // reference model: owner (-1 = none), last finisher, shown grant id, idle run
  int   m_owner, m_last, m_gid, m_stall;
  bit   m_abort;
  logic [16:0] exp_vec;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .USEDW_W(UW), .HIGH_WATER(HW), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
    .grant_id(grant_id), .busy(busy), .stall_abort(stall_abort)
  );

  function automatic logic [16:0] obs_vec();
    return {busy, grant_id, stall_abort, fifo_wrreq, req_ready, (fifo_wrreq ? fifo_data : 8'h00)};
  endfunction

  function automatic bit has_room();
    return !fifo_full && (int'(fifo_usedw) < HW);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gid = 0; m_stall = 0; m_abort = 1'b0;
  endtask

  task automatic push_pkt(input int i, input logic [7:0] first, input int len);
    for (int k = 0; k < len; k++) q[i].push_back({(k == len - 1), 8'(first + k)});
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_full = 1'b0; fifo_usedw = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin q[i].delete(); src_on[i] = 1'b0; hold[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_srcs(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_data[i]  = q[i][0][7:0];
        req_last[i]  = q[i][0][8];
        req_valid[i] = hold[i] || (src_on[i] && (!rnd || $urandom_range(0, 3) != 0));
      end else begin
        req_data[i] = 8'h00; req_last[i] = 1'b0; req_valid[i] = 1'b0;
      end
    end
  endtask

  // Expected outputs for the current cycle from model state and present inputs.
  task automatic predict();
    bit beat; logic [3:0] rdy; logic [7:0] d;
    beat = 1'b0; rdy = 4'h0; d = 8'h00;
    if (m_owner >= 0) begin
      beat = req_valid[m_owner] && has_room();
      if (beat) begin rdy[m_owner] = 1'b1; d = req_data[m_owner]; end
    end
    exp_vec = {(m_owner >= 0), 2'(m_gid), m_abort, beat, rdy, d};
  endtask

  // Apply the arbitration rules for this cycle, then cross the clock edge.
  task automatic advance();
    bit room, found, ab; logic [N-1:0] rdy_obs; int c;
    room = has_room(); rdy_obs = req_ready; ab = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (room) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req_valid[c]) begin found = 1'b1; m_owner = c; m_gid = c; m_stall = 0; end
        end
      end
      m_abort = 1'b0;
    end else begin
      if (req_valid[m_owner] && room) begin
        m_stall = 0;
        if (req_last[m_owner]) begin m_last = m_owner; m_owner = -1; end
      end else if (!req_valid[m_owner] && room) begin
        m_stall++;
        if (m_stall == SL) begin ab = 1'b1; m_last = m_owner; m_owner = -1; m_stall = 0; end
      end
      m_abort = ab;
    end
    for (int i = 0; i < N; i++) hold[i] = req_valid[i] && !rdy_obs[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy_obs[i]) void'(q[i].pop_front());
  endtask

  task automatic test_reset();
    do_reset();
    drive_srcs(1'b0); #2; predict();
    checks++;
    if (obs_vec() !== exp_vec) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec); end
    checks++;
    if ({busy, grant_id, stall_abort, fifo_wrreq, req_ready} !== 9'b0)
      begin errors++; $display("FAIL reset_state got=%b exp=0", {busy, grant_id, stall_abort, fifo_wrreq, req_ready}); end
    advance();
  endtask

  task automatic test_single();
    logic [4:0] lb, lw, eb;
    logic [7:0] ld [5];
    logic [1:0] lg [5];
    eb = 5'b01110;
    do_reset(); push_pkt(1, 8'hA1, 3); src_on[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL single c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      lb[c] = busy; lw[c] = fifo_wrreq; ld[c] = fifo_data; lg[c] = grant_id;
      advance();
    end
    checks++;
    if (lb !== eb || lw !== eb) begin errors++; $display("FAIL single_timing busy=%b wr=%b exp=%b", lb, lw, eb); end
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (ld[c] !== 8'(8'hA0 + c) || lg[c] !== 2'd1)
        begin errors++; $display("FAIL single_data c=%0d got=%h/%0d exp=%h/1", c, ld[c], lg[c], 8'(8'hA0 + c)); end
    end
  endtask

  task automatic test_round_robin();
    int gs[$]; int gc[$]; bit pb;
    do_reset(); pb = 1'b0;
    for (int i = 0; i < N; i++) begin
      push_pkt(i, 8'(16 * i + 1), 2); push_pkt(i, 8'(16 * i + 5), 2); src_on[i] = 1'b1;
    end
    for (int c = 0; c < 16; c++) begin
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL rr c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (busy && !pb) begin gs.push_back(int'(grant_id)); gc.push_back(c); end
      pb = busy;
      advance();
    end
    checks++;
    if (gs.size() != 5) begin
      errors++; $display("FAIL rr_count got=%0d exp=5", gs.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gs[k] != k % N || gc[k] != 1 + 3 * k)
          begin errors++; $display("FAIL rr_order k=%0d got=%0d@%0d exp=%0d@%0d", k, gs[k], gc[k], k % N, 1 + 3 * k); end
      end
    end
  endtask

  task automatic test_high_water();
    logic [7:0] st[$]; int win;
    do_reset(); win = 0; push_pkt(0, 8'h10, 6); src_on[0] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      fifo_usedw = (c >= 3 && c <= 8) ? 8'd250 : ((c >= 9) ? 8'd249 : 8'd0);
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL hw c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (fifo_wrreq === 1'b1) st.push_back(fifo_data);
      if ((c >= 3 && c <= 8) && (fifo_wrreq !== 1'b0 || req_ready !== 4'h0)) win++;
      advance();
    end
    checks++;
    if (win != 0) begin errors++; $display("FAIL hw_block got=%0d writes exp=0", win); end
    checks++;
    if (st.size() != 6) begin
      errors++; $display("FAIL hw_count got=%0d exp=6", st.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (st[k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL hw_stream k=%0d got=%h exp=%h", k, st[k], 8'(8'h10 + k)); end
      end
    end
  endtask

  task automatic test_stall_abort();
    int ab[$]; int g_after; bit pb;
    // owner 2 stalls; full cycles do not count; req3 waits and takes over
    do_reset(); g_after = -1; pb = 1'b0;
    push_pkt(2, 8'h20, 2); push_pkt(3, 8'h30, 1); src_on[3] = 1'b1;
    for (int c = 0; c < 42; c++) begin
      src_on[2] = (c < 2); fifo_full = (c >= 2 && c <= 21);
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL stall c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (stall_abort === 1'b1) ab.push_back(c);
      if (c > 38 && busy && !pb && g_after < 0) g_after = int'(grant_id);
      pb = busy;
      advance();
    end
    checks++;
    if (ab.size() != 1 || ab[0] != 38) begin errors++; $display("FAIL stall_pulse got=%0d pulses first=%0d exp=1@38", ab.size(), (ab.size() > 0) ? ab[0] : -1); end
    checks++;
    if (g_after != 3) begin errors++; $display("FAIL stall_next got=%0d exp=3", g_after); end
    // nobody else waiting: after reclaim of 2, requester 0 beats 1
    do_reset(); ab.delete(); g_after = -1;
    push_pkt(2, 8'h50, 2); push_pkt(0, 8'h60, 1); push_pkt(1, 8'h70, 1);
    for (int c = 0; c < 22; c++) begin
      src_on[2] = (c < 2); src_on[0] = (c >= 18); src_on[1] = (c >= 18);
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL stall2 c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (stall_abort === 1'b1) ab.push_back(c);
      if (c == 19) g_after = busy ? int'(grant_id) : -1;
      advance();
    end
    checks++;
    if (ab.size() != 1 || ab[0] != 18) begin errors++; $display("FAIL stall2_pulse got=%0d pulses first=%0d exp=1@18", ab.size(), (ab.size() > 0) ? ab[0] : -1); end
    checks++;
    if (g_after != 0) begin errors++; $display("FAIL stall2_next got=%0d exp=0", g_after); end
  endtask

  task automatic test_reset_mid();
    do_reset(); push_pkt(0, 8'h40, 5); src_on[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL rstmid c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (c == 4) begin
        checks++;
        if ({busy, grant_id, stall_abort, fifo_wrreq, req_ready} !== 9'b0)
          begin errors++; $display("FAIL rstmid_drop got=%b exp=0", {busy, grant_id, stall_abort, fifo_wrreq, req_ready}); end
      end
      if (c == 5) begin
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_data !== 8'h43)
          begin errors++; $display("FAIL rstmid_regrant got=%b/%0d/%h exp=1/0/43", busy, grant_id, fifo_data); end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_full_flag();
    int nw;
    do_reset(); nw = 0; push_pkt(1, 8'h80, 3); src_on[1] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      fifo_full = (c < 5) || (c >= 7 && c <= 10);
      drive_srcs(1'b0); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL full c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (fifo_wrreq === 1'b1) nw++;
      if (c == 4) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_idle got=%b exp=0", busy); end
      end
      if (c == 9) begin
        checks++;
        if (busy !== 1'b1 || fifo_wrreq !== 1'b0) begin errors++; $display("FAIL full_hold got=%b/%b exp=1/0", busy, fifo_wrreq); end
      end
      advance();
    end
    checks++;
    if (nw != 3) begin errors++; $display("FAIL full_writes got=%0d exp=3", nw); end
  endtask

  task automatic test_random();
    int total, nw;
    do_reset(); total = 0; nw = 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 6; p++) begin
        int len;
        len = $urandom_range(1, 4); total += len;
        push_pkt(i, 8'($urandom_range(0, 255)), len);
      end
      src_on[i] = 1'b1;
    end
    for (int c = 0; c < 600; c++) begin
      fifo_usedw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 200));
      fifo_full  = ($urandom_range(0, 15) == 0);
      drive_srcs(1'b1); #2; predict(); checks++;
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec); end
      if (fifo_wrreq === 1'b1) nw++;
      advance();
    end
    checks++;
    if (nw != total) begin errors++; $display("FAIL random_bytes got=%0d exp=%0d", nw, total); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_usedw = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_high_water();
    test_stall_abort();
    test_reset_mid();
    test_full_flag();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
